instr_decode: RTL and testbench
===============================

# instr_decode

Decode stage of the non-forwarding MIPS-Lite pipeline, directly downstream of instruction fetch. It holds the IF/ID pipeline register and the 32×32 register file, decodes the fetched word, and detects RAW hazards against in-flight writers. It drives `hazard_detected`, `halt_detected` and the branch-flush behaviour back to fetch, and presents a registered ID/EX bundle to execute.

## Interface
Parameters:
- `ADD_WIDTH`, 32, PC / address width (shared package constant).
- `INSTRUCTION_WIDTH`, 32, instruction word width.
- `NUM_REGS`, 32, register file depth (index width 5).

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-low reset (sampled on posedge `clock`).
- `instruction`  in  32  word from fetch (`Instruct`).
- `pc`  in  ADD_WIDTH  PC of `instruction`.
- `is_taken`  in  1  branch/jump resolved taken in EX; flush.
- `mem_dest`, `mem_dest_valid`  in  5, 1  destination of the instruction in EX/MEM.
- `wb_en`, `wb_rd`, `wb_data`  in  1, 5, 32  register file write port (from WB).
- `hazard_detected`  out  1  stall request to fetch (combinational).
- `halt_detected`  out  1  sticky; HALT has been decoded.
- `id_ex`  out  `IdEx` struct  {valid, opcode, rs_val, rt_val, imm (sign-extended 32), dest, dest_valid, pc}.
- `stall_count`  out  32  number of hazard stall cycles since reset.

## Operation
- Formats: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0]. R-type = ADD, SUB, MUL, OR, AND, XOR (opcodes 0x00, 0x02, 0x04, 0x06, 0x08, 0x0A). The matching I-type is opcode+1. LDW 0x0C, STW 0x0D, BZ 0x0E, BEQ 0x0F, JR 0x10, HALT 0x11.
- Sources:
  - R-type, STW, BEQ: rs and rt.
  - I-type arithmetic, LDW, BZ, JR: rs only.
  - HALT: none.
- Destinations:
  - R-type: rd.
  - I-type arithmetic, LDW: rt.
  - Others: `dest_valid=0`.
- Any other opcode (including 0xDEADBEEF → opcode 0x37) is illegal: decoded as a bubble, no hazard, no halt.
- R0 reads 0. Writes to R0 are dropped.
- Register file is write-through: a read with `wb_en && wb_rd==src && src!=0` returns `wb_data` in the same cycle. A WB writer never causes a stall.
- Hazard: IF/ID valid, a used source is non-zero, and it equals either:
  - the ID/EX dest with `id_ex.valid && id_ex.dest_valid`, or
  - `mem_dest` with `mem_dest_valid`.
- Update priority each posedge: `!rst` > `is_taken` > `halt_detected` > hazard > normal.
  - `!rst`: every register and output cleared to 0, including all 32 registers.
  - `is_taken`: IF/ID ← bubble and ID/EX ← bubble; the hazard is ignored that cycle (`hazard_detected` is gated by `!is_taken`).
  - `halt_detected` set: IF/ID and ID/EX hold bubbles; the register file still accepts writes so the pipeline drains.
  - Hazard: IF/ID holds, ID/EX ← bubble, `stall_count` +1 (wraps at 2^32).
  - Normal: IF/ID ← {`instruction`, `pc`, valid=1}; ID/EX ← decoded bundle.
- HALT in a valid IF/ID without hazard: it passes into ID/EX as a valid HALT, and `halt_detected` sets on the same edge and stays set until reset.

## Timing
- Latency is 2 edges: a word presented at edge N is in IF/ID after N and in ID/EX after N+1.
- `hazard_detected` is combinational from IF/ID, ID/EX and `mem_dest*`, and is valid in the same cycle. Fetch holds its PC on it.
- Stall length for a consumer directly behind a producer: 2 cycles. For a producer 2 ahead: 1 cycle.
- The register write at edge N is visible to a same-cycle read through the bypass. It is visible from the array after N.
- Reset mid-stall or mid-flush leaves no residue: all outputs are 0 the cycle after reset is sampled low.

## Structure
- Shared package `Types`:
  - opcode enum `Opcode`
  - `IdEx` struct
  - `REG_IDX_WIDTH`=5
  - `NOP_BUBBLE` constant
  - existing `ADD_WIDTH`, `INSTRUCTION_WIDTH`, `Instruct`
- Sub-module `reg_file`: 32×32 storage, two combinational read ports with write-through bypass, one synchronous write port, synchronous active-low clear, R0 hardwired to 0.
- Decode is a combinational function in the package; the hazard compare lives in `instr_decode`.

## Test plan
- Reset low for 2 cycles with random inputs → all outputs 0, `id_ex.valid=0`, `stall_count=0`. Then `ADDI R1,R0,5` at pc 0 → after 2 edges `id_ex` = {opcode 0x01, rs_val 0, imm 5, dest 1, dest_valid 1, pc 0}.
- `ADD R3,R1,R2` in IF/ID while ID/EX holds a writer of R1 → `hazard_detected=1` for 2 cycles, IF/ID holds, 2 bubbles are issued, `stall_count=2`. With `mem_dest=2` only → 1 stall cycle.
- `wb_en=1, wb_rd=4, wb_data=0xCAFEF00D`, and `SUB R5,R4,R4` in IF/ID the same cycle → no stall, and after the edge `rs_val=rt_val=0xCAFEF00D`.
- `is_taken=1` while IF/ID holds a valid instruction and a hazard is present → `hazard_detected=0`, and next cycle IF/ID and ID/EX are bubbles. Input 0xDEADBEEF → bubble, no halt.
- HALT (0x44000000) → `halt_detected=1` after the edge and a valid HALT in ID/EX. Subsequent words are ignored, and a `wb_en` write to R7 still lands. Reset low → `halt_detected=0`.

Source files
------------

// File: rtl/instr_decode_pkg.sv
// rtl/instr_decode_pkg.sv - shared types, constants and decode function for the decode stage
package instr_decode_pkg;
    localparam int ADD_WIDTH         = 32;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int DATA_WIDTH        = 32;
    localparam int NUM_REGS          = 32;
    localparam int REG_IDX_WIDTH     = 5;

    typedef logic [INSTRUCTION_WIDTH-1:0] instruct_t;

    typedef enum logic [5:0] {
        OP_ADD  = 6'h00, OP_ADDI = 6'h01, OP_SUB  = 6'h02, OP_SUBI = 6'h03,
        OP_MUL  = 6'h04, OP_MULI = 6'h05, OP_OR   = 6'h06, OP_ORI  = 6'h07,
        OP_AND  = 6'h08, OP_ANDI = 6'h09, OP_XOR  = 6'h0A, OP_XORI = 6'h0B,
        OP_LDW  = 6'h0C, OP_STW  = 6'h0D, OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F,
        OP_JR   = 6'h10, OP_HALT = 6'h11
    } opcode_e;

    typedef struct packed {
        logic                     valid;
        opcode_e                  opcode;
        logic [DATA_WIDTH-1:0]    rs_val;
        logic [DATA_WIDTH-1:0]    rt_val;
        logic [DATA_WIDTH-1:0]    imm;
        logic [REG_IDX_WIDTH-1:0] dest;
        logic                     dest_valid;
        logic [ADD_WIDTH-1:0]     pc;
    } id_ex_t;

    localparam id_ex_t NOP_BUBBLE = '0;

    typedef struct packed {
        logic                     legal;
        logic                     uses_rs;
        logic                     uses_rt;
        logic                     is_halt;
        opcode_e                  opcode;
        logic [REG_IDX_WIDTH-1:0] rs;
        logic [REG_IDX_WIDTH-1:0] rt;
        logic [REG_IDX_WIDTH-1:0] dest;
        logic                     dest_valid;
        logic [DATA_WIDTH-1:0]    imm;
    } dec_t;

    // Arithmetic ops come in pairs: even opcode is R-type, odd is the immediate form.
    function automatic dec_t decode(input instruct_t w);
        dec_t       d;
        logic [5:0] op;
        op       = w[31:26];
        d        = '0;
        d.opcode = opcode_e'(op);
        d.rs     = w[25:21];
        d.rt     = w[20:16];
        d.imm    = {{16{w[15]}}, w[15:0]};
        if (op <= OP_XORI) begin
            d.legal      = 1'b1;
            d.uses_rs    = 1'b1;
            d.uses_rt    = !op[0];
            d.dest       = op[0] ? w[20:16] : w[15:11];
            d.dest_valid = 1'b1;
        end else begin
            case (op)
                OP_LDW: begin
                    d.legal      = 1'b1;
                    d.uses_rs    = 1'b1;
                    d.dest       = w[20:16];
                    d.dest_valid = 1'b1;
                end
                OP_STW, OP_BEQ: begin
                    d.legal   = 1'b1;
                    d.uses_rs = 1'b1;
                    d.uses_rt = 1'b1;
                end
                OP_BZ, OP_JR: begin
                    d.legal   = 1'b1;
                    d.uses_rs = 1'b1;
                end
                OP_HALT: begin
                    d.legal   = 1'b1;
                    d.is_halt = 1'b1;
                end
                default: ;
            endcase
        end
        return d;
    endfunction
endpackage

// File: rtl/instr_decode_reg_file.sv
// rtl/instr_decode_reg_file.sv - 32x32 register file, two write-through read ports, R0 fixed at zero
module instr_decode_reg_file
    import instr_decode_pkg::*;
(
    input  logic                     clock,
    input  logic                     rst,
    input  logic [REG_IDX_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0]    rd_data_a,
    input  logic [REG_IDX_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0]    rd_data_b,
    input  logic                     wr_en,
    input  logic [REG_IDX_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clock) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Same-cycle write is forwarded so a WB producer never costs a stall.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if (rd_addr_a == '0)                          rd_data_a = '0;
        else if (wr_en && wr_addr == rd_addr_a)       rd_data_a = wr_data;
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        if (rd_addr_b == '0)                          rd_data_b = '0;
        else if (wr_en && wr_addr == rd_addr_b)       rd_data_b = wr_data;
    end
endmodule

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - decode stage: IF/ID register, register file, RAW hazard detect, ID/EX register
module instr_decode
    import instr_decode_pkg::*;
(
    input  logic                         clock,
    input  logic                         rst,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    input  logic [ADD_WIDTH-1:0]         pc,
    input  logic                         is_taken,
    input  logic [REG_IDX_WIDTH-1:0]     mem_dest,
    input  logic                         mem_dest_valid,
    input  logic                         wb_en,
    input  logic [REG_IDX_WIDTH-1:0]     wb_rd,
    input  logic [DATA_WIDTH-1:0]        wb_data,
    output logic                         hazard_detected,
    output logic                         halt_detected,
    output id_ex_t                       id_ex,
    output logic [31:0]                  stall_count
);
    logic                  ifid_valid;
    instruct_t             ifid_instr;
    logic [ADD_WIDTH-1:0]  ifid_pc;
    dec_t                  dec;
    logic [DATA_WIDTH-1:0] rs_val;
    logic [DATA_WIDTH-1:0] rt_val;
    logic                  rs_busy;
    logic                  rt_busy;
    logic                  hazard_raw;
    id_ex_t                next_id_ex;

    assign dec = decode(ifid_instr);

    instr_decode_reg_file u_rf (
        .clock     (clock),
        .rst       (rst),
        .rd_addr_a (dec.rs),
        .rd_data_a (rs_val),
        .rd_addr_b (dec.rt),
        .rd_data_b (rt_val),
        .wr_en     (wb_en),
        .wr_addr   (wb_rd),
        .wr_data   (wb_data)
    );

    // Writers still in EX (our ID/EX) or in MEM block a read; WB is covered by the bypass.
    always_comb begin
        rs_busy = (dec.rs != '0) &&
                  ((id_ex.valid && id_ex.dest_valid && id_ex.dest == dec.rs) ||
                   (mem_dest_valid && mem_dest == dec.rs));
        rt_busy = (dec.rt != '0) &&
                  ((id_ex.valid && id_ex.dest_valid && id_ex.dest == dec.rt) ||
                   (mem_dest_valid && mem_dest == dec.rt));
        hazard_raw = ifid_valid && ((dec.uses_rs && rs_busy) || (dec.uses_rt && rt_busy));
    end

    assign hazard_detected = hazard_raw && !is_taken && !halt_detected;

    always_comb begin
        next_id_ex = NOP_BUBBLE;
        if (ifid_valid && dec.legal) begin
            next_id_ex.valid      = 1'b1;
            next_id_ex.opcode     = dec.opcode;
            next_id_ex.rs_val     = rs_val;
            next_id_ex.rt_val     = rt_val;
            next_id_ex.imm        = dec.imm;
            next_id_ex.dest       = dec.dest;
            next_id_ex.dest_valid = dec.dest_valid;
            next_id_ex.pc         = ifid_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            ifid_valid    <= 1'b0;
            ifid_instr    <= '0;
            ifid_pc       <= '0;
            id_ex         <= NOP_BUBBLE;
            halt_detected <= 1'b0;
            stall_count   <= '0;
        end else if (is_taken || halt_detected) begin
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            id_ex      <= NOP_BUBBLE;
        end else if (hazard_detected) begin
            id_ex       <= NOP_BUBBLE;
            stall_count <= stall_count + 32'd1;
        end else begin
            ifid_valid <= 1'b1;
            ifid_instr <= instruction;
            ifid_pc    <= pc;
            id_ex      <= next_id_ex;
            if (ifid_valid && dec.is_halt) halt_detected <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_decode.sv
// tb/tb_instr_decode.sv - directed vector table plus randomized run against a behavioural pipeline model
module tb_instr_decode;
    import instr_decode_pkg::*;

    logic        clock;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        is_taken;
    logic [4:0]  mem_dest;
    logic        mem_dest_valid;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        hazard_detected;
    logic        halt_detected;
    id_ex_t      id_ex;
    logic [31:0] stall_count;

    instr_decode dut (
        .clock           (clock),
        .rst             (rst),
        .instruction     (instruction),
        .pc              (pc),
        .is_taken        (is_taken),
        .mem_dest        (mem_dest),
        .mem_dest_valid  (mem_dest_valid),
        .wb_en           (wb_en),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .hazard_detected (hazard_detected),
        .halt_detected   (halt_detected),
        .id_ex           (id_ex),
        .stall_count     (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: architectural registers, one fetched slot, one issued slot.
    logic [31:0] m_regs [32];
    bit          m_ifv;
    logic [31:0] m_ifw;
    logic [31:0] m_ifpc;
    id_ex_t      m_idex;
    bit          m_halt;
    logic [31:0] m_stall;
    bit          synced = 0;

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wb_en && wb_rd == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic bit is_rtype(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0A};
    endfunction

    function automatic bit is_iarith(input logic [5:0] op);
        return op inside {6'h01, 6'h03, 6'h05, 6'h07, 6'h09, 6'h0B};
    endfunction

    function automatic id_ex_t m_decode(input logic [31:0] w, input logic [31:0] wpc);
        id_ex_t     r;
        logic [5:0] op;
        op = w[31:26];
        r  = '0;
        if (op > 6'h11) return r;
        r.valid  = 1'b1;
        r.opcode = opcode_e'(op);
        r.rs_val = m_read(w[25:21]);
        r.rt_val = m_read(w[20:16]);
        r.imm    = {{16{w[15]}}, w[15:0]};
        r.pc     = wpc;
        if (is_rtype(op)) begin
            r.dest = w[15:11]; r.dest_valid = 1'b1;
        end else if (is_iarith(op) || op == 6'h0C) begin
            r.dest = w[20:16]; r.dest_valid = 1'b1;
        end
        return r;
    endfunction

    function automatic bit m_busy(input logic [4:0] r);
        if (r == 0) return 1'b0;
        return (m_idex.valid && m_idex.dest_valid && m_idex.dest == r) ||
               (mem_dest_valid && mem_dest == r);
    endfunction

    function automatic bit m_hazard();
        logic [5:0] op;
        bit         use_rs, use_rt;
        if (!m_ifv || is_taken || m_halt) return 1'b0;
        op     = m_ifw[31:26];
        use_rs = op <= 6'h10;
        use_rt = is_rtype(op) || op == 6'h0D || op == 6'h0F;
        return (use_rs && m_busy(m_ifw[25:21])) || (use_rt && m_busy(m_ifw[20:16]));
    endfunction

    task automatic model_step();
        id_ex_t nxt;
        bit     h;
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_ifv = 0; m_ifw = '0; m_ifpc = '0; m_idex = '0;
            m_halt = 0; m_stall = '0; synced = 1;
            return;
        end
        h = m_hazard();
        if (is_taken || m_halt) begin
            m_ifv = 0; m_idex = '0;
        end else if (h) begin
            m_idex  = '0;
            m_stall = m_stall + 1;
        end else begin
            nxt = m_ifv ? m_decode(m_ifw, m_ifpc) : '0;
            if (nxt.valid && nxt.opcode == OP_HALT) m_halt = 1;
            m_idex = nxt; m_ifv = 1; m_ifw = instruction; m_ifpc = pc;
        end
        if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
    endtask

    task automatic pre_check();
        if (synced) chk("model_hazard", {31'd0, hazard_detected}, {31'd0, m_hazard()});
    endtask

    task automatic post_check();
        if (synced) begin
            checks++;
            if (id_ex !== m_idex) begin
                errors++;
                $display("FAIL model_id_ex: got %h expected %h", id_ex, m_idex);
            end
            chk("model_halt", {31'd0, halt_detected}, {31'd0, m_halt});
            chk("model_stall", stall_count, m_stall);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        taken;
        logic [4:0]  md;
        logic        mdv;
        logic        wbe;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic        chk_haz;
        logic        exp_haz;
        logic        exp_valid;
        logic [5:0]  exp_op;
        logic [4:0]  exp_dest;
        logic        chk_rs;
        logic [31:0] exp_rs;
        logic        exp_halt;
        logic [31:0] exp_stall;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(
        input logic r, input logic [31:0] w, input logic [31:0] p, input logic tk,
        input logic [4:0] md, input logic mdv, input logic we, input logic [4:0] wr, input logic [31:0] wd,
        input logic ch, input logic eh, input logic ev, input logic [5:0] eop, input logic [4:0] ed,
        input logic cr, input logic [31:0] ers, input logic ehl, input logic [31:0] est);
        vec_t v;
        v = '{r, w, p, tk, md, mdv, we, wr, wd, ch, eh, ev, eop, ed, cr, ers, ehl, est};
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rst = v.rst; instruction = v.instr; pc = v.pc; is_taken = v.taken;
        mem_dest = v.md; mem_dest_valid = v.mdv; wb_en = v.wbe; wb_rd = v.wrd; wb_data = v.wdat;
    endtask

    function automatic logic [31:0] rand_instr();
        int         k;
        logic [5:0] op;
        k = $urandom_range(0, 39);
        if (k == 0) return 32'h44000000 | ($urandom() & 32'h03FF_FFFF);
        if (k == 1) return $urandom();
        op = 6'($urandom_range(0, 16));
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 11'($urandom())};
    endfunction

    initial begin
        logic [31:0] w_or, w_xor;
        w_or  = enc_r(6'h06, 6, 0, 0);
        w_xor = enc_r(6'h0A, 10, 0, 0);
        //          rst instr                     pc     tk md mdv we wr wdat          ch eh ev op     dst cr rs            hl stall
        vecs.push_back(mk(0, 32'hFFFF_FFFF,          32'h1234, 1, 3, 1, 1, 3, 32'h55,      0, 0, 0, 6'h00, 0, 0, 0,            0, 0));
        vecs.push_back(mk(0, enc_r(6'h00, 1, 2, 3),  8,        0, 0, 0, 1, 9, 32'h99,      1, 0, 0, 6'h00, 0, 0, 0,            0, 0));
        vecs.push_back(mk(1, enc_i(6'h01, 1, 0, 5),  0,        0, 0, 0, 0, 0, 0,           1, 0, 0, 6'h00, 0, 0, 0,            0, 0));
        vecs.push_back(mk(1, enc_i(6'h01, 2, 0, 7),  4,        0, 0, 0, 0, 0, 0,           1, 0, 1, 6'h01, 1, 1, 0,            0, 0));
        vecs.push_back(mk(1, enc_r(6'h00, 3, 1, 2),  8,        0, 0, 0, 0, 0, 0,           1, 0, 1, 6'h01, 2, 0, 0,            0, 0));
        vecs.push_back(mk(1, w_or,                   12,       0, 1, 1, 0, 0, 0,           1, 1, 0, 6'h00, 0, 0, 0,            0, 1));
        vecs.push_back(mk(1, w_or,                   12,       0, 2, 1, 0, 0, 0,           1, 1, 0, 6'h00, 0, 0, 0,            0, 2));
        vecs.push_back(mk(1, w_or,                   12,       0, 0, 0, 0, 0, 0,           1, 0, 1, 6'h00, 3, 0, 0,            0, 2));
        vecs.push_back(mk(1, enc_r(6'h00, 9, 8, 0),  16,       0, 3, 1, 0, 0, 0,           1, 0, 1, 6'h06, 6, 0, 0,            0, 2));
        vecs.push_back(mk(1, w_xor,                  20,       0, 8, 1, 0, 0, 0,           1, 1, 0, 6'h00, 0, 0, 0,            0, 3));
        vecs.push_back(mk(1, w_xor,                  20,       0, 0, 0, 0, 0, 0,           1, 0, 1, 6'h00, 9, 0, 0,            0, 3));
        vecs.push_back(mk(1, enc_r(6'h02, 5, 4, 4),  24,       0, 0, 0, 1, 4, 32'h1111_1111, 1, 0, 1, 6'h0A, 10, 0, 0,          0, 3));
        vecs.push_back(mk(1, enc_r(6'h00, 0, 0, 0),  28,       0, 0, 0, 1, 4, 32'hCAFE_F00D, 1, 0, 1, 6'h02, 5, 1, 32'hCAFE_F00D, 0, 3));
        vecs.push_back(mk(1, enc_r(6'h00, 11, 5, 0), 32,       0, 0, 0, 0, 0, 0,           1, 0, 1, 6'h00, 0, 0, 0,            0, 3));
        vecs.push_back(mk(1, enc_i(6'h01, 12, 0, 1), 36,       1, 5, 1, 0, 0, 0,           1, 0, 0, 6'h00, 0, 0, 0,            0, 3));
        vecs.push_back(mk(1, 32'hDEAD_BEEF,          40,       0, 0, 0, 0, 0, 0,           1, 0, 0, 6'h00, 0, 0, 0,            0, 3));
        vecs.push_back(mk(1, 32'h4400_0000,          44,       0, 0, 0, 0, 0, 0,           1, 0, 0, 6'h00, 0, 0, 0,            0, 3));
        vecs.push_back(mk(1, enc_i(6'h01, 7, 0, 3),  48,       0, 0, 0, 0, 0, 0,           1, 0, 1, 6'h11, 0, 0, 0,            1, 3));
        vecs.push_back(mk(1, enc_r(6'h00, 8, 7, 0),  52,       0, 0, 0, 1, 7, 32'h77,      1, 0, 0, 6'h00, 0, 0, 0,            1, 3));
        vecs.push_back(mk(1, enc_r(6'h00, 8, 7, 7),  56,       0, 7, 1, 0, 0, 0,           1, 0, 0, 6'h00, 0, 0, 0,            1, 3));
        vecs.push_back(mk(0, 32'h1234_5678,          60,       1, 7, 1, 1, 7, 32'h88,      1, 0, 0, 6'h00, 0, 0, 0,            0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            #2;
            pre_check();
            if (vecs[i].chk_haz) chk($sformatf("tbl%0d_hazard", i), {31'd0, hazard_detected}, {31'd0, vecs[i].exp_haz});
            @(posedge clock);
            model_step();
            #1;
            post_check();
            chk($sformatf("tbl%0d_valid", i), {31'd0, id_ex.valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk($sformatf("tbl%0d_opcode", i), {26'd0, id_ex.opcode}, {26'd0, vecs[i].exp_op});
                chk($sformatf("tbl%0d_dest", i), {27'd0, id_ex.dest}, {27'd0, vecs[i].exp_dest});
            end
            if (vecs[i].chk_rs) begin
                chk($sformatf("tbl%0d_rs_val", i), id_ex.rs_val, vecs[i].exp_rs);
                chk($sformatf("tbl%0d_rt_val", i), id_ex.rt_val, vecs[i].exp_rs);
            end
            chk($sformatf("tbl%0d_halt", i), {31'd0, halt_detected}, {31'd0, vecs[i].exp_halt});
            chk($sformatf("tbl%0d_stall", i), stall_count, vecs[i].exp_stall);
            if (i == 19) chk("halt_r7_write", dut.u_rf.regs[7], 32'h77);
            @(negedge clock);
        end

        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 59) != 0);
            instruction    = rand_instr();
            pc             = $urandom();
            is_taken       = ($urandom_range(0, 7) == 0);
            mem_dest       = 5'($urandom_range(0, 7));
            mem_dest_valid = 1'($urandom());
            wb_en          = 1'($urandom());
            wb_rd          = 5'($urandom_range(0, 7));
            wb_data        = $urandom();
            #2;
            pre_check();
            @(posedge clock);
            model_step();
            #1;
            post_check();
            @(negedge clock);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
